// File: rtl/ps2_mouse_ctrl_if.sv
// ----------------------------------------------------------------------------
// ps2_mouse_ctrl_if
// Byte-level handshake between the PS/2 mouse protocol engine (master) and
// the generic PS/2 byte interface (slave).
//   oreq    : 1-clk strobe, request transmit of obyte   (master -> slave)
//   obyte   : byte to transmit, stable from oreq to oack (master -> slave)
//   oack    : 1-clk strobe, transmit complete            (slave -> master)
//   istrobe : 1-clk strobe, ibyte holds a received byte  (slave -> master)
//   ibyte   : received byte                              (slave -> master)
//   timeout : 1-clk strobe, line idle/timeout            (slave -> master)
// ----------------------------------------------------------------------------
interface ps2_mouse_ctrl_if;
    logic       oreq;
    logic [7:0] obyte;
    logic       oack;
    logic       istrobe;
    logic [7:0] ibyte;
    logic       timeout;

    modport master (
        output oreq,
        output obyte,
        input  oack,
        input  istrobe,
        input  ibyte,
        input  timeout
    );

    modport slave (
        input  oreq,
        input  obyte,
        output oack,
        output istrobe,
        output ibyte,
        output timeout
    );
endinterface

// File: rtl/ps2_mouse_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_mouse_ctrl
// PS/2 mouse protocol engine. Resets the mouse (FF), waits for ACK/BAT/ID,
// enables data reporting (F4), then assembles 3-byte stream packets into
// signed 9-bit X/Y deltas plus the left button state.
// Ports:
//   sysclk, reset  : clock, asynchronous active-high reset
//   ps2            : byte handshake to the PS/2 byte interface (master side)
//   pkt_valid      : 1-clk strobe, dx/dy/button carry a new packet
//   dx, dy         : two's complement deltas (+right, +up), held between packets
//   button         : left button (1 = pressed), held between packets
//   init_done      : high while in the stream states
//   init_err       : sticky, set once restarts exceed INIT_RETRIES
// ----------------------------------------------------------------------------
module ps2_mouse_ctrl #(
    parameter int BAT_TIMEOUTS = 2,
    parameter int INIT_RETRIES = 7
) (
    input  logic                    sysclk,
    input  logic                    reset,
    ps2_mouse_ctrl_if.master        ps2,
    output logic                    pkt_valid,
    output logic [8:0]              dx,
    output logic [8:0]              dy,
    output logic                    button,
    output logic                    init_done,
    output logic                    init_err
);

    // Retry counter must be able to hold INIT_RETRIES+1 so "exceeds" is visible.
    localparam int RW = $clog2(INIT_RETRIES + 2);
    localparam int BW = (BAT_TIMEOUTS > 0) ? $clog2(BAT_TIMEOUTS + 1) : 1;

    typedef enum logic [3:0] {
        S_SEND_RST  = 4'd0,
        S_TX_RST    = 4'd1,
        S_WAIT_ACK1 = 4'd2,
        S_WAIT_BAT  = 4'd3,
        S_WAIT_ID   = 4'd4,
        S_SEND_EN   = 4'd5,
        S_TX_EN     = 4'd6,
        S_WAIT_ACK2 = 4'd7,
        S_B0        = 4'd8,
        S_B1        = 4'd9,
        S_B2        = 4'd10
    } state_t;

    state_t         state_q, state_d;
    logic           oreq_q, oreq_d;
    logic [7:0]     obyte_q, obyte_d;
    logic           pkt_valid_q, pkt_valid_d;
    logic [8:0]     dx_q, dx_d;
    logic [8:0]     dy_q, dy_d;
    logic           button_q, button_d;
    logic           init_done_q, init_done_d;
    logic           init_err_q, init_err_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [BW-1:0]  bat_to_q, bat_to_d;
    logic [7:0]     flag_q, flag_d;
    logic [7:0]     xbyte_q, xbyte_d;
    logic           restart_s;

    // Overflow forces the delta to the extreme of its sign; otherwise sign-extend.
    function automatic logic [8:0] clamp_delta(input logic ovf, input logic sgn,
                                               input logic [7:0] mag);
        logic [8:0] res;
        if (ovf) begin
            res = sgn ? 9'h100 : 9'h0FF;
        end else begin
            res = {sgn, mag};
        end
        return res;
    endfunction

    // Next-state, handshake and packet assembly logic.
    always_comb begin
        state_d     = state_q;
        oreq_d      = 1'b0;
        obyte_d     = obyte_q;
        pkt_valid_d = 1'b0;
        dx_d        = dx_q;
        dy_d        = dy_q;
        button_d    = button_q;
        retry_d     = retry_q;
        bat_to_d    = bat_to_q;
        flag_d      = flag_q;
        xbyte_d     = xbyte_q;
        restart_s   = 1'b0;

        case (state_q)
            // The SEND states spend one cycle raising oreq, then leave with
            // oreq already dropping, so oreq is never seen in a TX state.
            S_SEND_RST: begin
                if (oreq_q) begin
                    state_d = S_TX_RST;
                end else begin
                    oreq_d  = 1'b1;
                    obyte_d = 8'hFF;
                end
            end
            S_TX_RST: begin
                if (ps2.oack) begin
                    state_d = S_WAIT_ACK1;
                end else if (ps2.timeout) begin
                    restart_s = 1'b1;
                end else begin
                    state_d = S_TX_RST;
                end
            end
            S_WAIT_ACK1: begin
                if (ps2.istrobe) begin
                    if (ps2.ibyte == 8'hFA) begin
                        state_d  = S_WAIT_BAT;
                        bat_to_d = {BW{1'b0}};
                    end else begin
                        restart_s = 1'b1;
                    end
                end else if (ps2.timeout) begin
                    restart_s = 1'b1;
                end else begin
                    state_d = S_WAIT_ACK1;
                end
            end
            // BAT can take a long time; only the timeout after the tolerated
            // count restarts. Other bytes are ignored here.
            S_WAIT_BAT: begin
                if (ps2.istrobe) begin
                    if (ps2.ibyte == 8'hAA) begin
                        state_d = S_WAIT_ID;
                    end else if (ps2.ibyte == 8'hFC) begin
                        restart_s = 1'b1;
                    end else begin
                        state_d = S_WAIT_BAT;
                    end
                end else if (ps2.timeout) begin
                    if (bat_to_q == BW'(BAT_TIMEOUTS)) begin
                        restart_s = 1'b1;
                    end else begin
                        bat_to_d = bat_to_q + BW'(1);
                    end
                end else begin
                    state_d = S_WAIT_BAT;
                end
            end
            S_WAIT_ID: begin
                if (ps2.istrobe) begin
                    if (ps2.ibyte == 8'h00) begin
                        state_d = S_SEND_EN;
                    end else begin
                        restart_s = 1'b1;
                    end
                end else if (ps2.timeout) begin
                    restart_s = 1'b1;
                end else begin
                    state_d = S_WAIT_ID;
                end
            end
            S_SEND_EN: begin
                if (oreq_q) begin
                    state_d = S_TX_EN;
                end else begin
                    oreq_d  = 1'b1;
                    obyte_d = 8'hF4;
                end
            end
            S_TX_EN: begin
                if (ps2.oack) begin
                    state_d = S_WAIT_ACK2;
                end else if (ps2.timeout) begin
                    restart_s = 1'b1;
                end else begin
                    state_d = S_TX_EN;
                end
            end
            S_WAIT_ACK2: begin
                if (ps2.istrobe) begin
                    if (ps2.ibyte == 8'hFA) begin
                        state_d = S_B0;
                    end else begin
                        restart_s = 1'b1;
                    end
                end else if (ps2.timeout) begin
                    restart_s = 1'b1;
                end else begin
                    state_d = S_WAIT_ACK2;
                end
            end
            // AA here is a hot-plug BAT; bytes without bit 3 cannot be a flag
            // byte and are dropped to regain packet alignment.
            S_B0: begin
                if (ps2.istrobe) begin
                    if (ps2.ibyte == 8'hAA) begin
                        state_d = S_WAIT_ID;
                    end else if (ps2.ibyte[3]) begin
                        flag_d  = ps2.ibyte;
                        state_d = S_B1;
                    end else begin
                        state_d = S_B0;
                    end
                end else begin
                    state_d = S_B0;
                end
            end
            S_B1: begin
                if (ps2.istrobe) begin
                    xbyte_d = ps2.ibyte;
                    state_d = S_B2;
                end else if (ps2.timeout) begin
                    state_d = S_B0;
                end else begin
                    state_d = S_B1;
                end
            end
            S_B2: begin
                if (ps2.istrobe) begin
                    pkt_valid_d = 1'b1;
                    dx_d        = clamp_delta(flag_q[6], flag_q[4], xbyte_q);
                    dy_d        = clamp_delta(flag_q[7], flag_q[5], ps2.ibyte);
                    button_d    = flag_q[0];
                    state_d     = S_B0;
                end else if (ps2.timeout) begin
                    state_d = S_B0;
                end else begin
                    state_d = S_B2;
                end
            end
            default: begin
                state_d = S_SEND_RST;
            end
        endcase

        if (restart_s) begin
            state_d = S_SEND_RST;
            if (retry_q != {RW{1'b1}}) begin
                retry_d = retry_q + RW'(1);
            end else begin
                retry_d = retry_q;
            end
        end else begin
            retry_d = retry_d;
        end

        init_err_d  = init_err_q | (retry_d > RW'(INIT_RETRIES));
        init_done_d = (state_d == S_B0) || (state_d == S_B1) || (state_d == S_B2);
    end

    // State and output registers.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_SEND_RST;
            oreq_q      <= 1'b0;
            obyte_q     <= 8'hFF;
            pkt_valid_q <= 1'b0;
            dx_q        <= 9'h000;
            dy_q        <= 9'h000;
            button_q    <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            retry_q     <= {RW{1'b0}};
            bat_to_q    <= {BW{1'b0}};
            flag_q      <= 8'h00;
            xbyte_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            oreq_q      <= oreq_d;
            obyte_q     <= obyte_d;
            pkt_valid_q <= pkt_valid_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            button_q    <= button_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
            retry_q     <= retry_d;
            bat_to_q    <= bat_to_d;
            flag_q      <= flag_d;
            xbyte_q     <= xbyte_d;
        end
    end

    assign ps2.oreq  = oreq_q;
    assign ps2.obyte = obyte_q;
    assign pkt_valid = pkt_valid_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign button    = button_q;
    assign init_done = init_done_q;
    assign init_err  = init_err_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
module tb_ps2_mouse_ctrl;

    logic       sysclk;
    logic       reset;
    logic       pkt_valid;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       button;
    logic       init_done;
    logic       init_err;

    int compared   = 0;
    int mismatched = 0;
    int oreq_cnt   = 0;
    int pkt_cnt    = 0;

    ps2_mouse_ctrl_if bus ();

    ps2_mouse_ctrl #(.BAT_TIMEOUTS(2), .INIT_RETRIES(7)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .ps2       (bus),
        .pkt_valid (pkt_valid),
        .dx        (dx),
        .dy        (dy),
        .button    (button),
        .init_done (init_done),
        .init_err  (init_err)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Count oreq and pkt_valid pulses, sampled just after each rising edge.
    always begin
        @(posedge sysclk);
        #1;
        if (bus.oreq === 1'b1) oreq_cnt++;
        if (pkt_valid === 1'b1) pkt_cnt++;
    end

    // Expected packet from the protocol rules: {button, dx, dy}.
    function automatic logic [18:0] model(input logic [7:0] f, input logic [7:0] x,
                                          input logic [7:0] y);
        int vx, vy;
        vx = f[4] ? int'(x) - 256 : int'(x);
        vy = f[5] ? int'(y) - 256 : int'(y);
        if (f[6]) vx = f[4] ? -256 : 255;
        if (f[7]) vy = f[5] ? -256 : 255;
        return {f[0], 9'(vx), 9'(vy)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        bus.istrobe = 1'b1;
        bus.ibyte   = b;
        @(negedge sysclk);
        bus.istrobe = 1'b0;
    endtask

    task automatic pulse_to();
        bus.timeout = 1'b1;
        @(negedge sysclk);
        bus.timeout = 1'b0;
    endtask

    task automatic expect_tx(input logic [7:0] b, input string tag);
        int n = 0;
        while (bus.oreq !== 1'b1 && n < 10) begin
            @(negedge sysclk);
            n++;
        end
        chk({tag, "_oreq"}, bus.oreq, 1'b1);
        chk({tag, "_obyte"}, bus.obyte, b);
        repeat (2) @(negedge sysclk);
        chk({tag, "_oreq_low"}, bus.oreq, 1'b0);
        chk({tag, "_obyte_hold"}, bus.obyte, b);
        bus.oack = 1'b1;
        @(negedge sysclk);
        bus.oack = 1'b0;
    endtask

    task automatic do_init(input bit collide);
        expect_tx(8'hFF, "init_ff");
        if (collide) bus.timeout = 1'b1;
        send_byte(8'hFA);
        bus.timeout = 1'b0;
        send_byte(8'hAA);
        send_byte(8'h00);
        expect_tx(8'hF4, "init_f4");
        send_byte(8'hFA);
        chk("init_done", init_done, 1'b1);
    endtask

    task automatic send_pkt(input logic [7:0] f, input logic [7:0] x, input logic [7:0] y,
                            input string tag);
        logic [18:0] e;
        e = model(f, x, y);
        send_byte(f);
        chk({tag, "_pv0"}, pkt_valid, 1'b0);
        send_byte(x);
        chk({tag, "_pv1"}, pkt_valid, 1'b0);
        send_byte(y);
        chk({tag, "_pv"}, pkt_valid, 1'b1);
        chk({tag, "_dx"}, dx, e[17:9]);
        chk({tag, "_dy"}, dy, e[8:0]);
        chk({tag, "_btn"}, button, e[18]);
        @(negedge sysclk);
        chk({tag, "_pv_off"}, pkt_valid, 1'b0);
        chk({tag, "_dx_hold"}, dx, e[17:9]);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] f, x, y;
        int o0, p0;
        reset       = 1'b1;
        bus.istrobe = 1'b0;
        bus.ibyte   = 8'h00;
        bus.oack    = 1'b0;
        bus.timeout = 1'b0;
        repeat (3) @(negedge sysclk);

        chk("rst_oreq", bus.oreq, 1'b0);
        chk("rst_obyte", bus.obyte, 8'hFF);
        chk("rst_pv", pkt_valid, 1'b0);
        chk("rst_dx", dx, 9'h000);
        chk("rst_dy", dy, 9'h000);
        chk("rst_btn", button, 1'b0);
        chk("rst_done", init_done, 1'b0);
        chk("rst_err", init_err, 1'b0);

        // Clean init; FA arrives together with a timeout (istrobe wins).
        reset = 1'b0;
        o0 = oreq_cnt;
        @(negedge sysclk);
        chk("first_oreq", bus.oreq, 1'b1);
        do_init(1'b1);
        repeat (2) @(negedge sysclk);
        chk("init_oreq_count", oreq_cnt - o0, 2);
        chk("init_err_clean", init_err, 1'b0);

        // Directed packets.
        send_pkt(8'h09, 8'h05, 8'hFE, "pkt1");
        send_pkt(8'h18, 8'hFB, 8'h03, "pkt2");
        send_pkt(8'h5A, 8'h10, 8'h20, "ovf");
        send_pkt(8'h88, 8'h7F, 8'h80, "yovf");
        send_byte(8'h00);
        chk("resync_pv", pkt_valid, 1'b0);
        chk("resync_done", init_done, 1'b1);
        send_pkt(8'h08, 8'h00, 8'h00, "resync");

        // Random packets, occasionally preceded by a non-flag byte.
        for (int i = 0; i < 24; i++) begin
            f = 8'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            if (f == 8'hAA) f = 8'h08;
            if (!f[3]) begin
                send_byte(f);
                chk("rnd_discard", pkt_valid, 1'b0);
                f[3] = 1'b1;
            end
            send_pkt(f, x, y, "rnd");
        end

        // Stream timeouts: B1 discards partial packet, B0 is ignored.
        p0 = pkt_cnt;
        send_byte(8'h08);
        pulse_to();
        pulse_to();
        chk("b0_to_done", init_done, 1'b1);
        send_pkt(8'h08, 8'h01, 8'h01, "to_pkt");
        repeat (2) @(negedge sysclk);
        chk("to_pkt_count", pkt_cnt - p0, 1);

        // Hot-plug: AA in B0 goes straight to ID wait then F4.
        o0 = oreq_cnt;
        send_byte(8'hAA);
        chk("hp_done", init_done, 1'b0);
        send_byte(8'h00);
        expect_tx(8'hF4, "hp_f4");
        send_byte(8'hFA);
        chk("hp_redone", init_done, 1'b1);
        chk("hp_oreq_count", oreq_cnt - o0, 1);

        // Reset in B1.
        send_byte(8'h08);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_oreq", bus.oreq, 1'b0);
        chk("mid_rst_obyte", bus.obyte, 8'hFF);
        chk("mid_rst_dx", dx, 9'h000);
        chk("mid_rst_dy", dy, 9'h000);
        chk("mid_rst_btn", button, 1'b0);
        chk("mid_rst_done", init_done, 1'b0);
        @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        chk("mid_rst_oreq1", bus.oreq, 1'b1);
        do_init(1'b0);

        // BAT timeouts: two tolerated, third restarts.
        pulse_reset();
        expect_tx(8'hFF, "bat_ff");
        send_byte(8'hFA);
        pulse_to();
        pulse_to();
        o0 = oreq_cnt;
        repeat (5) @(negedge sysclk);
        chk("bat_no_restart", oreq_cnt - o0, 0);
        pulse_to();
        expect_tx(8'hFF, "bat_restart");
        chk("bat_restart_count", oreq_cnt - o0, 1);
        send_byte(8'hFA);
        send_byte(8'hAA);
        send_byte(8'h00);
        expect_tx(8'hF4, "bat_f4");
        send_byte(8'hFA);
        chk("bat_done", init_done, 1'b1);

        // Init failure: eight NAKs to FF set the sticky error.
        pulse_reset();
        for (int i = 1; i <= 8; i++) begin
            expect_tx(8'hFF, "fail_ff");
            send_byte(8'hFE);
            chk("fail_err", init_err, (i >= 8) ? 1'b1 : 1'b0);
        end
        do_init(1'b0);
        chk("fail_err_sticky", init_err, 1'b1);
        pulse_reset();
        chk("err_cleared", init_err, 1'b0);

        repeat (3) @(negedge sysclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
